// File: rtl/fht_frame_ctrl.sv
// Frame sequencer for fht_top: scatters one sample frame into the four
// input banks, kicks the transform, then streams the result banks out.
module fht_frame_ctrl #(
   parameter int D_BIT  = 16,
   parameter int A_BIT  = 8,
   parameter int RD_LAT = 2
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iEN,
   input  logic [D_BIT-1:0] iS_DATA,
   input  logic             iS_VALID,
   output logic             oS_READY,
   output logic [3:0]       oWE,
   output logic [D_BIT-1:0] oDATA_WR,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic             oSTART,
   input  logic             iFHT_RDY,
   output logic [A_BIT-1:0] oADDR_RD,
   input  logic [D_BIT-1:0] iRD_DATA_0,
   input  logic [D_BIT-1:0] iRD_DATA_1,
   input  logic [D_BIT-1:0] iRD_DATA_2,
   input  logic [D_BIT-1:0] iRD_DATA_3,
   output logic [D_BIT-1:0] oM_DATA_0,
   output logic [D_BIT-1:0] oM_DATA_1,
   output logic [D_BIT-1:0] oM_DATA_2,
   output logic [D_BIT-1:0] oM_DATA_3,
   output logic             oM_VALID,
   input  logic             iM_READY,
   output logic             oBUSY,
   output logic             oFRAME_DONE,
   output logic [23:0]      oRUN_CYC
);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_LO, RUN, DRAIN
   } state_t;

   localparam logic [A_BIT+1:0] K_LAST = '1;
   localparam logic [A_BIT-1:0] B_LAST = '1;

   state_t              state, state_nxt;
   logic [A_BIT+1:0]    k;
   logic [A_BIT:0]      r;
   logic [A_BIT-1:0]    beat;
   logic [23:0]         acc;
   logic [RD_LAT-1:0]   vld;
   logic [2:0]          inflight;
   logic [2:0]          fifo_cnt;
   logic [1:0]          wp, rp;
   logic [4*D_BIT-1:0]  fifo [4];
   logic [4*D_BIT-1:0]  head;
   logic                s_hs, load_last, issue, arrive, pop;

   assign oS_READY  = (state == LOAD);
   assign s_hs      = iS_VALID & oS_READY;
   assign load_last = s_hs & (k == K_LAST);
   assign oBUSY     = (state != IDLE);
   assign oADDR_RD  = r[A_BIT-1:0];

   // Credit rule: never have more reads outstanding than free FIFO slots.
   assign issue  = (state == DRAIN) & ~r[A_BIT] &
                   (({1'b0, fifo_cnt} + {1'b0, inflight}) < 4'd4);
   assign arrive = vld[RD_LAT-1];

   assign oM_VALID    = (fifo_cnt != 3'd0);
   assign pop         = oM_VALID & iM_READY;
   assign oFRAME_DONE = pop & (beat == B_LAST);

   assign head      = oM_VALID ? fifo[rp] : '0;
   assign oM_DATA_0 = head[D_BIT-1:0];
   assign oM_DATA_1 = head[2*D_BIT-1:D_BIT];
   assign oM_DATA_2 = head[3*D_BIT-1:2*D_BIT];
   assign oM_DATA_3 = head[4*D_BIT-1:3*D_BIT];

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (iEN) state_nxt = LOAD;
         LOAD:    if (load_last) state_nxt = START;
         START:   state_nxt = WAIT_LO;
         WAIT_LO: if (!iFHT_RDY) state_nxt = RUN;
         RUN:     if (iFHT_RDY) state_nxt = DRAIN;
         DRAIN:   if (oFRAME_DONE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state    <= IDLE;
         k        <= '0;
         oWE      <= '0;
         oDATA_WR <= '0;
         oADDR_WR <= '0;
         oSTART   <= 1'b0;
         acc      <= '0;
         r        <= '0;
         beat     <= '0;
         vld      <= '0;
         inflight <= '0;
         fifo_cnt <= '0;
         wp       <= '0;
         rp       <= '0;
      end else begin
         state  <= state_nxt;
         oSTART <= (state == START);
         oWE    <= '0;
         if (s_hs) begin
            oWE      <= 4'b0001 << k[1:0];
            oADDR_WR <= k[A_BIT+1:2];
            oDATA_WR <= iS_DATA;
            k        <= k + (A_BIT+2)'(1);
         end
         // Every RDY-low cycle after the start pulse counts, WAIT_LO included.
         if (state == START)
            acc <= '0;
         else if (!iFHT_RDY && (state == WAIT_LO || state == RUN) &&
                  acc != 24'hFF_FFFF)
            acc <= acc + 24'd1;
         if (state != DRAIN)
            r <= '0;
         else if (issue)
            r <= r + (A_BIT+1)'(1);
         vld      <= (vld << 1) | RD_LAT'(issue);
         inflight <= inflight + 3'(issue) - 3'(arrive);
         fifo_cnt <= fifo_cnt + 3'(arrive) - 3'(pop);
         if (arrive) wp <= wp + 2'd1;
         if (pop) begin
            rp   <= rp + 2'd1;
            beat <= beat + A_BIT'(1);
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (arrive)
         fifo[wp] <= {iRD_DATA_3, iRD_DATA_2, iRD_DATA_1, iRD_DATA_0};
   end

   always_ff @(posedge iCLK) begin
      if (!iRESET && state == RUN && iFHT_RDY)
         oRUN_CYC <= acc;
   end

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// Bench for fht_frame_ctrl: RAM/transform model, write and beat
// scoreboards, randomized gaps, backpressure and mid-frame resets.
module tb_fht_frame_ctrl;

   localparam int D  = 16;
   localparam int A  = 3;
   localparam int L  = 2;
   localparam int N  = 4 << A;
   localparam int NB = 1 << A;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [D-1:0]  s_data = '0;
   logic          s_valid = 1'b0;
   logic          m_ready = 1'b1;
   logic          s_ready, start, fht_rdy, m_valid, busy, frame_done;
   logic [3:0]    we;
   logic [D-1:0]  data_wr;
   logic [A-1:0]  addr_wr, addr_rd;
   logic [D-1:0]  rd [4];
   logic [D-1:0]  md0, md1, md2, md3;
   logic [23:0]   run_cyc;

   always #5 clk = ~clk;

   fht_frame_ctrl #(.D_BIT(D), .A_BIT(A), .RD_LAT(L)) dut (
      .iCLK(clk), .iRESET(rst), .iEN(en),
      .iS_DATA(s_data), .iS_VALID(s_valid), .oS_READY(s_ready),
      .oWE(we), .oDATA_WR(data_wr), .oADDR_WR(addr_wr),
      .oSTART(start), .iFHT_RDY(fht_rdy), .oADDR_RD(addr_rd),
      .iRD_DATA_0(rd[0]), .iRD_DATA_1(rd[1]),
      .iRD_DATA_2(rd[2]), .iRD_DATA_3(rd[3]),
      .oM_DATA_0(md0), .oM_DATA_1(md1), .oM_DATA_2(md2), .oM_DATA_3(md3),
      .oM_VALID(m_valid), .iM_READY(m_ready),
      .oBUSY(busy), .oFRAME_DONE(frame_done), .oRUN_CYC(run_cyc)
   );

   int tests = 0;
   int fails = 0;
   int low_cyc = 100;
   int rmode = 0;
   int stall = 0;
   int beats_seen = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int t = 0;
   logic [22:0]  wq [$];
   logic [63:0]  bq [$];
   logic [D-1:0] frame [N];
   logic [D-1:0] ram [4][NB];
   logic [A-1:0] a1;

   // Identity transform: four banks, RD_LAT=2 read pipe, RDY low low_cyc cycles.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) ram[b][addr_wr] <= data_wr;
         rd[b] <= ram[b][a1];
      end
      a1 <= addr_rd;
      if (start) t <= 1;
      else if (t != 0) t <= (t >= low_cyc + 1) ? 0 : t + 1;
   end
   assign fht_rdy = (t < 2);

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always begin
      tick();
      if (rmode == 0) m_ready = 1'b1;
      else if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (beats_seen >= 3 && stall < 10) begin
         m_ready = 1'b0;
         stall++;
      end else if (stall >= 10) m_ready = ~m_ready;
      else m_ready = 1'b1;
   end

   logic        prev_stall = 1'b0;
   logic        saw_valid = 1'b0;
   logic        prev_last_wr = 1'b0;
   logic [63:0] prev_data = '0;

   always @(negedge clk) begin
      logic [63:0] d, e;
      logic [22:0] w;
      logic        last_wr;
      d = {md3, md2, md1, md0};
      last_wr = 1'b0;
      if (rst) begin
         saw_valid = 1'b0;
         prev_stall = 1'b0;
         prev_last_wr = 1'b0;
      end else begin
         if (we != 4'd0) begin
            tests++;
            if (wq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: we=%b addr=%0d", we, addr_wr);
            end else begin
               w = wq.pop_front();
               chk("write", {41'd0, we, addr_wr, data_wr}, {41'd0, w});
               last_wr = (w[22:16] == {4'b1000, 3'(NB - 1)});
            end
         end
         if (start) begin
            start_cnt++;
            chk("start_after_last_write", prev_last_wr, 1);
         end
         prev_last_wr = last_wr;
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", d, prev_data);
         end
         if (rmode == 0 && saw_valid) chk("valid_continuous", m_valid, 1);
         if (m_valid) saw_valid = 1'b1;
         if (m_valid && m_ready) begin
            tests++;
            if (bq.size() == 0) begin
               fails++;
               $display("FAIL extra_beat: got %0h, expected none", d);
            end else begin
               e = bq.pop_front();
               chk("beat", d, e);
            end
            beats_seen++;
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_on_last_accept",
                {m_valid & m_ready, 32'(bq.size())}, {1'b1, 32'd0});
            saw_valid = 1'b0;
         end
         prev_stall = m_valid & ~m_ready;
         prev_data = d;
      end
   end

   task automatic chk_zero(input string name);
      @(negedge clk);
      chk({name, "_ctrl"},
          {s_ready, we, data_wr, addr_wr, start, addr_rd,
           m_valid, busy, frame_done}, 0);
      chk({name, "_data"}, {md3, md2, md1, md0}, 0);
   endtask

   task automatic load(input int n, input int mode, input bit ramp);
      int  k = 0;
      int  cyc = 0;
      bit  hs;
      while (k < n && cyc < 1000) begin
         case (mode)
            0: s_valid = 1'b1;
            1: s_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: s_valid = 1'($urandom_range(0, 1));
         endcase
         s_data = ramp ? D'(k) : D'($urandom);
         @(negedge clk);
         hs = s_valid && s_ready;
         tick();
         if (hs) begin
            frame[k] = s_data;
            wq.push_back({4'b0001 << (k % 4), 3'(k / 4), s_data});
            k++;
         end
         cyc++;
      end
      s_valid = 1'b0;
      chk("load_count", k, n);
   endtask

   task automatic arm();
      en = 1'b1;
      tick();
      en = 1'b0;
   endtask

   task automatic push_beats();
      for (int j = 0; j < NB; j++)
         bq.push_back({frame[4*j+3], frame[4*j+2], frame[4*j+1], frame[4*j]});
   endtask

   task automatic setup(input int rm, input int lowc);
      rmode = rm;
      stall = 0;
      low_cyc = lowc;
      start_cnt = 0;
      done_cnt = 0;
      beats_seen = 0;
   endtask

   task automatic run_frame(input int lmode, input int rm, input int lowc,
                            input bit ramp);
      bit busy_ok = 1'b1;
      bit done = 1'b0;
      int cyc = 0;
      setup(rm, lowc);
      arm();
      load(N, lmode, ramp);
      push_beats();
      while (!done && cyc < 3000) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         done = frame_done;
         cyc++;
      end
      tick();
      chk("frame_done_seen", done, 1);
      chk("busy_during_frame", busy_ok, 1);
      chk("idle_after_done", {busy, m_valid, s_ready}, 0);
      chk("done_pulses", done_cnt, 1);
      chk("start_pulses", start_cnt, 1);
      chk("beat_count", beats_seen, NB);
      chk("run_cyc", run_cyc, 24'(lowc));
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wq.delete();
      bq.delete();
      beats_seen = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      repeat (3) tick();
      rst = 1'b0;
      wq.delete();
      chk_zero("reset_state");

      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ignores_valid", {s_ready, we, busy}, 0);
      end
      tick();
      s_valid = 1'b0;

      run_frame(0, 0, 100, 1'b1);
      run_frame(1, 2, 100, 1'b0);

      setup(0, 40);
      arm();
      load(14, 0, 1'b0);
      reset_pulse();
      chk_zero("reset_mid_load");
      run_frame(2, 1, $urandom_range(1, 150), 1'b0);

      setup(0, 30);
      arm();
      load(N, 0, 1'b0);
      push_beats();
      cyc = 0;
      while (beats_seen < 3 && cyc < 2000) begin
         tick();
         cyc++;
      end
      chk("drain_reached_beat3", beats_seen >= 3, 1);
      reset_pulse();
      chk_zero("reset_mid_drain");
      chk("run_cyc_kept", run_cyc, 24'd30);
      run_frame(0, 0, 100, 1'b0);

      for (int i = 0; i < 3; i++)
         run_frame($urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(1, 150), 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fht_frame_ctrl.md
Name: fht_frame_ctrl

Overview:
- Frame sequencer that sits in front of fht_top and owns its external RAM ports.
- Accepts a stream of ADC samples and scatters them into the four banks of the FHT input RAM.
- Pulses iSTART to fht_top, waits for the transform to finish, then reads the four result banks back and streams them out as 4-wide beats with valid/ready flow control.
- Handles one frame per arm; a frame is N = 4*2^A_BIT samples.

Parameters:
- D_BIT, 16: sample / RAM word width.
- A_BIT, 8: per-bank address width.
- RD_LAT, 2: fht_top read latency in cycles, from oADDR_RD to iRD_DATA_x. Legal range 1..4.

Ports:
- iCLK  in  1  clock; single clock domain.
- iRESET  in  1  synchronous, active-high reset.
- iEN  in  1  arm; sampled only in IDLE.
- iS_DATA  in  D_BIT  input sample.
- iS_VALID  in  1  input sample valid.
- oS_READY  out  1  sample accepted when iS_VALID & oS_READY.
- oWE  out  4  one-hot bank write enable, to fht_top iWE.
- oDATA_WR  out  D_BIT  write data, fanned to iDATA_0..3.
- oADDR_WR  out  A_BIT  write address, fanned to iADDR_WR_0..3.
- oSTART  out  1  one-cycle start pulse to fht_top.
- iFHT_RDY  in  1  fht_top oRDY; high when idle, low while transforming.
- oADDR_RD  out  A_BIT  read address, fanned to iADDR_RD_0..3.
- iRD_DATA_0..3  in  D_BIT each  fht_top oDATA_0..3.
- oM_DATA_0..3  out  D_BIT each  output beat, one word per bank.
- oM_VALID  out  1  output beat valid.
- iM_READY  in  1  output beat accepted when oM_VALID & iM_READY.
- oBUSY  out  1  high in any state other than IDLE.
- oFRAME_DONE  out  1  one-cycle pulse when the last beat is accepted.
- oRUN_CYC  out  24  iFHT_RDY-low cycle count of the last frame; saturates at 2^24-1.

Behaviour:
- Reset (synchronous, iRESET=1 at a clock edge): state=IDLE; all outputs 0 except oRUN_CYC, which keeps its value. Load, read and in-flight counters and the output FIFO are cleared. Reset in any state aborts the frame; the next frame restarts at k=0.
- States: IDLE, LOAD, START, WAIT_LO, RUN, DRAIN.
- IDLE -> LOAD when iEN=1.
- LOAD:
  - oS_READY=1.
  - Each accepted sample with index k (0..N-1) is registered onto the write ports on the next cycle: oWE = 1<<k[1:0], oADDR_WR = k[A_BIT+1:2], oDATA_WR = sample.
  - No write occurs on cycles with no handshake; gaps on iS_VALID are allowed.
  - Acceptance of k=N-1 -> START; oS_READY drops in the same cycle the transition registers.
- START: oWE=0, oSTART=1 for exactly one cycle -> WAIT_LO.
- WAIT_LO: wait for iFHT_RDY=0 -> RUN. The oRUN_CYC accumulator clears on entry.
- RUN: accumulator increments every cycle iFHT_RDY=0. iFHT_RDY=1 -> DRAIN; oRUN_CYC is updated from the accumulator.
- DRAIN:
  - Read address counter r runs 0..2^A_BIT-1. A read at r is issued (oADDR_RD=r, r++) only when fifo_count + inflight < 4.
  - A RD_LAT-deep valid shift register tracks in-flight reads. When a slot arrives, iRD_DATA_0..3 is pushed into a 4-entry FIFO.
  - FIFO head drives oM_DATA_0..3 / oM_VALID. Pop on iM_READY & oM_VALID.
  - Push and pop in the same cycle leave the count unchanged. The FIFO can never overflow (credit rule). With iM_READY held high, throughput is 1 beat/cycle after RD_LAT fill.
  - Beat j carries bank words at address j, in natural order. No bit-reverse reordering is done here.
  - When the 2^A_BIT-th beat is accepted: oFRAME_DONE=1 for one cycle, -> IDLE.
- oM_DATA holds its value while oM_VALID=1 and iM_READY=0.
- iS_VALID outside LOAD is ignored (oS_READY=0). iEN changes after IDLE have no effect.

Test Plan:
Configuration for all scenarios: A_BIT=3 (N=32), RD_LAT=2, fht_top replaced by a 4-bank RAM model whose RDY drops 2 cycles after START and rises 100 cycles later.
1. Ramp load:
   - Stimulus: iEN=1, samples 0..31 with iS_VALID=1 continuously.
   - Response: oWE sequence 0001,0010,0100,1000 repeating; oADDR_WR 0,0,0,0,1,...,7. Sample 31 lands in bank 3, address 7. oSTART high exactly one cycle, the cycle after the last write.
2. Transform handshake:
   - Response: state moves WAIT_LO -> RUN -> DRAIN; oRUN_CYC=100; oBUSY=1 throughout.
3. Free-flowing drain:
   - Stimulus: iM_READY=1.
   - Response: 8 beats, beat j = {4j, 4j+1, 4j+2, 4j+3} (identity RAM model). oM_VALID is continuous from its first assertion. oFRAME_DONE pulses once, on acceptance of beat 7; state returns to IDLE, oBUSY=0.
4. Backpressure:
   - Stimulus: iM_READY=0 for 10 cycles mid-drain, then toggled 1/0.
   - Response: exactly 8 distinct beats in order, no duplicates. oADDR_RD stalls; fifo_count + inflight ≤ 4 at all times. oM_DATA is stable while stalled.
5. Mid-frame reset:
   - Stimulus: iRESET=1 for one cycle after sample 13 is accepted; then again during DRAIN at beat 3.
   - Response: all outputs 0 on the next cycle; state=IDLE. After re-arming, the first write goes to bank 0, address 0; the FIFO is empty.
6. Gaps and disarm:
   - Stimulus: iS_VALID pattern 1,0,0,1 during LOAD; iS_VALID=1 with iEN=0 in IDLE.
   - Response: writes occur only on handshakes, with indices consecutive. No oWE and oS_READY=0 while in IDLE.
